// File: rtl/voting_pkg.sv
// Shared types and helpers for the N-candidate voting machine.
// One-hot decoding helpers work on a 16-bit vector; callers zero-extend.
package voting_pkg;

    localparam int unsigned MAX_CAND  = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        COUNT    = 2'd2,
        WAIT_REL = 2'd3
    } vm_state_e;

    localparam logic MODE_VOTE    = 1'b0;
    localparam logic MODE_DISPLAY = 1'b1;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } onehot_t;

    function automatic logic is_single(input logic [MAX_CAND-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_CAND'(1))) == '0);
    endfunction

    function automatic onehot_t onehot_idx(input logic [MAX_CAND-1:0] vec);
        onehot_t res;
        res.valid = is_single(vec);
        res.idx   = '0;
        for (int i = 0; i < int'(MAX_CAND); i++) begin
            if (vec[i]) res.idx = MAX_IDX_W'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/vm_press_filter.sv
// Press filter: debounces a single held button into exactly one vote per press
// and rejects simultaneous multi-button presses.
module vm_press_filter
    import voting_pkg::*;
#(
    parameter int unsigned NUM_CAND     = 4,
    parameter int unsigned DEBOUNCE_CYC = 10
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_mode,
    input  logic [NUM_CAND-1:0]         i_buttons,
    output logic                        o_vote_valid,
    output logic [$clog2(NUM_CAND)-1:0] o_vote_idx,
    output logic                        o_invalid_press,
    output logic                        o_count_en_c,
    output logic [$clog2(NUM_CAND)-1:0] o_count_idx_c,
    output logic                        o_show_vote_c
);

    localparam int unsigned IDX_W = $clog2(NUM_CAND);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 2);

    vm_state_e           r_state, w_state_nxt;
    logic [NUM_CAND-1:0] r_pattern, w_pattern_nxt;
    logic [DB_W-1:0]     r_cnt, w_cnt_nxt;
    logic                r_voted, w_voted_nxt;
    logic                r_vote_valid, w_vote_valid_nxt;
    logic [IDX_W-1:0]    r_vote_idx, w_vote_idx_nxt;
    logic                r_invalid, w_invalid_nxt;
    logic                w_count_en;
    logic                w_single;
    onehot_t             w_lat;
    logic [IDX_W-1:0]    w_lat_idx;

    assign w_single  = is_single(MAX_CAND'(i_buttons));
    assign w_lat     = onehot_idx(MAX_CAND'(r_pattern));
    assign w_lat_idx = IDX_W'(w_lat.idx);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_pattern    <= '0;
            r_cnt        <= '0;
            r_voted      <= 1'b0;
            r_vote_valid <= 1'b0;
            r_vote_idx   <= '0;
            r_invalid    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pattern    <= w_pattern_nxt;
            r_cnt        <= w_cnt_nxt;
            r_voted      <= w_voted_nxt;
            r_vote_valid <= w_vote_valid_nxt;
            r_vote_idx   <= w_vote_idx_nxt;
            r_invalid    <= w_invalid_nxt;
        end
    end

    // Display mode aborts any press in flight; holding through a mode switch is a fresh press.
    always_comb begin
        w_state_nxt      = r_state;
        w_pattern_nxt    = r_pattern;
        w_cnt_nxt        = r_cnt;
        w_voted_nxt      = r_voted;
        w_vote_valid_nxt = 1'b0;
        w_vote_idx_nxt   = r_vote_idx;
        w_invalid_nxt    = 1'b0;
        w_count_en       = 1'b0;

        if (i_mode == MODE_DISPLAY) begin
            w_state_nxt = IDLE;
            w_voted_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_voted_nxt = 1'b0;
                    if (w_single) begin
                        w_pattern_nxt = i_buttons;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = DEBOUNCE;
                    end else if (i_buttons != '0) begin
                        w_invalid_nxt = 1'b1;
                        w_state_nxt   = WAIT_REL;
                    end
                end
                DEBOUNCE: begin
                    if (i_buttons == r_pattern) begin
                        w_cnt_nxt = r_cnt + DB_W'(1);
                        if (r_cnt == DB_LAST) w_state_nxt = COUNT;
                    end else if ((i_buttons == '0) || w_single) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_invalid_nxt = 1'b1;
                        w_state_nxt   = WAIT_REL;
                    end
                end
                COUNT: begin
                    w_count_en       = w_lat.valid;
                    w_vote_valid_nxt = 1'b1;
                    w_vote_idx_nxt   = w_lat_idx;
                    w_voted_nxt      = 1'b1;
                    w_state_nxt      = WAIT_REL;
                end
                WAIT_REL: begin
                    if (i_buttons == '0) begin
                        w_state_nxt = IDLE;
                        w_voted_nxt = 1'b0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign o_vote_valid    = r_vote_valid;
    assign o_vote_idx      = r_vote_idx;
    assign o_invalid_press = r_invalid;
    assign o_count_en_c    = w_count_en;
    assign o_count_idx_c   = w_lat_idx;
    assign o_show_vote_c   = (r_state == WAIT_REL) && r_voted;

endmodule

// File: rtl/voting_machine_n.sv
// N-candidate voting machine: saturating vote counters, live winner/tie
// tracking and the registered LED display mux around the press filter.
module voting_machine_n
    import voting_pkg::*;
#(
    parameter int unsigned NUM_CAND     = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned LED_W        = 8,
    parameter int unsigned DEBOUNCE_CYC = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mode,
    input  logic [NUM_CAND-1:0]         buttons,
    output logic [LED_W-1:0]            led,
    output logic                        vote_valid,
    output logic [$clog2(NUM_CAND)-1:0] vote_idx,
    output logic                        invalid_press,
    output logic [$clog2(NUM_CAND)-1:0] winner_idx,
    output logic                        tie
);

    localparam int unsigned IDX_W = $clog2(NUM_CAND);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (CNT_W > LED_W) begin : g_bad_width
        $error("voting_machine_n: CNT_W must not exceed LED_W");
    end
    if ((NUM_CAND < 2) || (NUM_CAND > MAX_CAND)) begin : g_bad_cand
        $error("voting_machine_n: NUM_CAND must be 2..16");
    end
    if (DEBOUNCE_CYC < 2) begin : g_bad_db
        $error("voting_machine_n: DEBOUNCE_CYC must be at least 2");
    end

    logic [CNT_W-1:0] r_cnt [NUM_CAND];
    logic [LED_W-1:0] r_led, w_led_nxt;
    logic [IDX_W-1:0] r_winner, w_winner;
    logic             r_tie, w_tie;
    logic [CNT_W-1:0] w_max;
    logic             w_count_en;
    logic [IDX_W-1:0] w_count_idx;
    logic             w_show_vote;
    logic [IDX_W-1:0] w_vote_idx;
    onehot_t          w_btn_oh;

    vm_press_filter #(
        .NUM_CAND     (NUM_CAND),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_filter (
        .i_clk           (clock),
        .i_rst           (reset),
        .i_mode          (mode),
        .i_buttons       (buttons),
        .o_vote_valid    (vote_valid),
        .o_vote_idx      (w_vote_idx),
        .o_invalid_press (invalid_press),
        .o_count_en_c    (w_count_en),
        .o_count_idx_c   (w_count_idx),
        .o_show_vote_c   (w_show_vote)
    );

    assign vote_idx = w_vote_idx;

    // Counters hold at max; the vote pulse still fires from the filter.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CAND); i++) r_cnt[i] <= '0;
        end else if (w_count_en && (r_cnt[w_count_idx] != CNT_MAX)) begin
            r_cnt[w_count_idx] <= r_cnt[w_count_idx] + CNT_W'(1);
        end
    end

    // Strict greater-than keeps the lowest index on equal counts.
    always_comb begin
        w_max    = '0;
        w_winner = '0;
        w_tie    = 1'b0;
        for (int i = 0; i < int'(NUM_CAND); i++) begin
            if (r_cnt[i] > w_max) begin
                w_max    = r_cnt[i];
                w_winner = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_CAND); i++) begin
            if ((r_cnt[i] == w_max) && (IDX_W'(i) != w_winner)) w_tie = 1'b1;
        end
        if (w_max == '0) w_tie = 1'b0;
    end

    assign w_btn_oh = onehot_idx(MAX_CAND'(buttons));

    always_comb begin
        w_led_nxt = '0;
        if (mode == MODE_DISPLAY) begin
            if (w_btn_oh.valid) w_led_nxt = LED_W'(r_cnt[IDX_W'(w_btn_oh.idx)]);
        end else if (w_show_vote) begin
            w_led_nxt = LED_W'(1) << w_vote_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_led    <= '0;
            r_winner <= '0;
            r_tie    <= 1'b0;
        end else begin
            r_led    <= w_led_nxt;
            r_winner <= w_winner;
            r_tie    <= w_tie;
        end
    end

    assign led        = r_led;
    assign winner_idx = r_winner;
    assign tie        = r_tie;

endmodule

// File: tb/tb_voting_machine_n.sv
// Directed bench for voting_machine_n: default instance plus a CNT_W=2 instance
// for counter saturation.
module tb_voting_machine_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode, mode2;
    logic [3:0] buttons, buttons2;
    logic [7:0] led, led2;
    logic       vote_valid, vote_valid2;
    logic [1:0] vote_idx, vote_idx2;
    logic       invalid_press, invalid_press2;
    logic [1:0] winner_idx, winner_idx2;
    logic       tie, tie2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vv_cnt   = 0;
    int vv2_cnt  = 0;
    int inv_cnt  = 0;
    int inv2_cnt = 0;
    int last_vv_cyc = 0;
    int base_vv, base_inv, base_vv2, base_inv2, p;

    always #5 clk = ~clk;

    voting_machine_n dut (
        .clock(clk), .reset(reset), .mode(mode), .buttons(buttons),
        .led(led), .vote_valid(vote_valid), .vote_idx(vote_idx),
        .invalid_press(invalid_press), .winner_idx(winner_idx), .tie(tie)
    );

    voting_machine_n #(.NUM_CAND(4), .CNT_W(2), .LED_W(8), .DEBOUNCE_CYC(10)) dut2 (
        .clock(clk), .reset(reset), .mode(mode2), .buttons(buttons2),
        .led(led2), .vote_valid(vote_valid2), .vote_idx(vote_idx2),
        .invalid_press(invalid_press2), .winner_idx(winner_idx2), .tie(tie2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (vote_valid) begin
            vv_cnt = vv_cnt + 1;
            last_vv_cyc = cyc;
        end
        if (vote_valid2) vv2_cnt = vv2_cnt + 1;
        if (invalid_press) inv_cnt = inv_cnt + 1;
        if (invalid_press2) inv2_cnt = inv2_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read a candidate count via display mode, then return cleanly to vote mode.
    task automatic show_count(input logic [3:0] btn, input string tag, input logic [7:0] exp);
        mode = 1'b1; buttons = btn;
        step(1);
        chk(tag, 32'(led), 32'(exp));
        buttons = 4'h0;
        step(1);
        mode = 1'b0;
        step(1);
    endtask

    task automatic press(input logic [3:0] btn, input int hold, input int gap);
        buttons = btn;
        step(hold);
        buttons = 4'h0;
        step(gap);
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; mode2 = 1'b0; buttons = 4'h0; buttons2 = 4'h0;
        step(3);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_vv", 32'(vote_valid), 32'h0);
        chk("rst_vidx", 32'(vote_idx), 32'h0);
        chk("rst_inv", 32'(invalid_press), 32'h0);
        chk("rst_win", 32'(winner_idx), 32'h0);
        chk("rst_tie", 32'(tie), 32'h0);
        chk("rst_led2", 32'(led2), 32'h0);
        reset = 1'b0;
        step(2);

        // Single long press of button0: one vote, 10 edges after the first sampled edge.
        base_vv = vv_cnt;
        buttons = 4'b0001; p = cyc;
        step(20);
        chk("hold_led_onehot0", 32'(led), 32'h01);
        step(5);
        buttons = 4'h0;
        step(2);
        chk("b0_vote_count", 32'(vv_cnt - base_vv), 32'd1);
        chk("b0_vote_latency", 32'(last_vv_cyc - p), 32'd11);
        chk("b0_vidx", 32'(vote_idx), 32'd0);
        chk("b0_led_after_rel", 32'(led), 32'h0);
        chk("b0_win", 32'(winner_idx), 32'd0);
        chk("b0_tie", 32'(tie), 32'd0);
        show_count(4'b0001, "cnt0_is1", 8'd1);

        // Short press then long press of button1.
        base_vv = vv_cnt;
        press(4'b0010, 5, 2);
        chk("short_no_vote", 32'(vv_cnt - base_vv), 32'd0);
        press(4'b0010, 20, 3);
        chk("b1_vote_count", 32'(vv_cnt - base_vv), 32'd1);
        chk("b1_vidx", 32'(vote_idx), 32'd1);
        chk("b1_tie", 32'(tie), 32'd1);
        chk("b1_win", 32'(winner_idx), 32'd0);

        // Multi-press rejected once; narrowing to one button while held must not vote.
        base_vv = vv_cnt; base_inv = inv_cnt;
        buttons = 4'b0110;
        step(30);
        chk("multi_led", 32'(led), 32'h0);
        buttons = 4'b0010;
        step(20);
        buttons = 4'h0;
        step(2);
        chk("multi_inv_once", 32'(inv_cnt - base_inv), 32'd1);
        chk("multi_no_vote", 32'(vv_cnt - base_vv), 32'd0);
        show_count(4'b0010, "disp_cnt1", 8'h01);
        show_count(4'b0110, "disp_multi_zero", 8'h00);
        show_count(4'b0100, "disp_cnt2_zero", 8'h00);

        // Mode switch mid-debounce aborts the press.
        base_vv = vv_cnt;
        buttons = 4'b1000;
        step(5);
        mode = 1'b1;
        step(8);
        buttons = 4'h0;
        step(1);
        mode = 1'b0;
        step(2);
        chk("mode_abort_no_vote", 32'(vv_cnt - base_vv), 32'd0);
        show_count(4'b1000, "disp_cnt3_zero", 8'h00);

        // Second vote for candidate 1 breaks the tie.
        press(4'b0010, 15, 3);
        chk("b1_lead_win", 32'(winner_idx), 32'd1);
        chk("b1_lead_tie", 32'(tie), 32'd0);
        show_count(4'b0010, "disp_cnt1_two", 8'h02);

        // Reset during debounce clears everything without a vote.
        base_vv = vv_cnt;
        buttons = 4'b0001;
        step(5);
        reset = 1'b1; buttons = 4'h0;
        step(1);
        chk("midrst_led", 32'(led), 32'h0);
        chk("midrst_win", 32'(winner_idx), 32'd0);
        chk("midrst_vidx", 32'(vote_idx), 32'd0);
        reset = 1'b0;
        step(2);
        chk("midrst_no_vote", 32'(vv_cnt - base_vv), 32'd0);
        chk("midrst_tie", 32'(tie), 32'd0);
        show_count(4'b0010, "midrst_cnt1_zero", 8'h00);
        base_vv = vv_cnt;
        press(4'b0001, 25, 3);
        chk("post_rst_vote", 32'(vv_cnt - base_vv), 32'd1);
        chk("post_rst_win", 32'(winner_idx), 32'd0);
        show_count(4'b0001, "post_rst_cnt0", 8'h01);

        // Saturation on the CNT_W=2 instance.
        base_vv2 = vv2_cnt; base_inv2 = inv2_cnt;
        for (int k = 0; k < 5; k++) begin
            buttons2 = 4'b0100;
            step(12);
            buttons2 = 4'h0;
            step(2);
        end
        chk("sat_pulses", 32'(vv2_cnt - base_vv2), 32'd5);
        chk("sat_inv", 32'(inv2_cnt - base_inv2), 32'd0);
        chk("sat_vidx", 32'(vote_idx2), 32'd2);
        chk("sat_win", 32'(winner_idx2), 32'd2);
        chk("sat_tie", 32'(tie2), 32'd0);
        mode2 = 1'b1; buttons2 = 4'b0100;
        step(1);
        chk("sat_cnt2", 32'(led2), 32'd3);
        buttons2 = 4'h0;
        step(1);
        mode2 = 1'b0;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voting_machine_n.md
Name: voting_machine_n

Overview:
Parametrised successor to the 4-button voting machine. It supports NUM_CAND candidates, a debounced one-vote-per-press filter, multi-press rejection and saturating counters. It also adds live winner/tie tracking. It sits between the raw push-button inputs and the LED/display logic, all on a single clock domain.

Parameters:
NUM_CAND, 4, number of candidates/buttons (2..16)
CNT_W, 8, vote counter width per candidate; counters saturate at 2^CNT_W-1
LED_W, 8, display width; CNT_W <= LED_W is required (elaboration $error otherwise)
DEBOUNCE_CYC, 10, consecutive stable cycles a single button must be held before a vote counts (>=2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
mode  input  1  0 = vote mode, 1 = display mode
buttons  input  NUM_CAND  raw button levels, bit i = candidate i
led  output  LED_W  display value (registered)
vote_valid  output  1  one-cycle pulse when a vote is counted
vote_idx  output  $clog2(NUM_CAND)  candidate of the last counted vote (held)
invalid_press  output  1  one-cycle pulse when a multi-button press is rejected
winner_idx  output  $clog2(NUM_CAND)  index of the highest count; lowest index wins ties
tie  output  1  two or more candidates share the max count and max > 0

Behaviour:
- Reset (clock edge with reset=1): all counters 0, FSM to IDLE, and led, vote_valid, vote_idx, invalid_press, winner_idx and tie all 0. Reset overrides every other input, including mid-debounce.
- Press filter FSM (active only when mode=0):
  - IDLE: buttons==0 stays IDLE. Exactly one bit set -> latch the pattern, clear the stable counter, go to DEBOUNCE. More than one bit set -> pulse invalid_press, go to WAIT_REL.
  - DEBOUNCE: buttons equal to the latched pattern -> increment the counter. When the count reaches DEBOUNCE_CYC-1 -> go to COUNT. Buttons==0 or a different single bit -> back to IDLE, no vote. Multiple bits set -> pulse invalid_press, go to WAIT_REL.
  - COUNT (one cycle): increment the counter for the latched index, saturating (no wrap at max). Pulse vote_valid, load vote_idx, go to WAIT_REL. The vote_valid pulse is asserted even when the counter is saturated.
  - WAIT_REL: stay until buttons==0, then go to IDLE. This guarantees one vote per press regardless of hold length.
- The vote is counted on the edge that is DEBOUNCE_CYC cycles after the first sampled press edge. Counters, vote_valid and vote_idx update on the same edge.
- mode=1: the FSM is forced to IDLE on the next edge and any in-progress press is aborted without a vote. If a button is still held when mode returns to 0, the FSM sees it as a fresh press.
- led, registered with 1-cycle latency:
  - mode=1 with exactly one button pressed: count of that candidate, zero-extended to LED_W.
  - mode=1 otherwise: 0.
  - mode=0: one-hot of vote_idx while the FSM is in WAIT_REL after a valid vote, else 0.
- Winner logic is registered and reflects the counters one cycle after a change. With all counts 0, winner_idx=0 and tie=0.
- Buttons are synchronous to clock; the testbench drives them on inactive edges. No metastability handling is required in this block.

Decomposition:
- Package voting_pkg:
  - state enum (IDLE, DEBOUNCE, COUNT, WAIT_REL)
  - MODE_VOTE/MODE_DISPLAY constants
  - function onehot_idx(vec) returning the index and a valid flag
  - function is_single(vec)
- Sub-module vm_press_filter (parameters NUM_CAND, DEBOUNCE_CYC): owns the FSM and stable counter and outputs vote_valid, vote_idx and invalid_press.
- The top level holds the counter array, the winner compare tree and the led mux.

Test Plan:
- Reset, then hold button0 for 25 cycles in mode 0 -> exactly one vote_valid, at the 10th cycle; count0=1; winner_idx=0; tie=0.
- Press button1 for 5 cycles, release, then hold it 20 cycles -> no vote on the short press; count1=1 after the long press; tie=1 (count0=count1=1); winner_idx=0.
- Hold button1|button2 together for 30 cycles -> invalid_press pulses once; counts unchanged; FSM returns to IDLE only after release.
- mode=1 with button1 held -> led=8'h01 one cycle later. mode=1 with button1|button2 held -> led=0. Toggle mode to 1 mid-debounce of button3 -> no vote, count3=0.
- With CNT_W=2, give candidate 2 five valid votes -> count2 stays at 3 and vote_valid still pulses 5 times; winner_idx=2.
- Assert reset during DEBOUNCE of button0 -> all counts 0, no vote_valid; a later press counts normally.
